// File: rtl/rv32m_muldiv.sv
`timescale 1ns/1ps
// rv32m_muldiv: iterative RV32M multiply/divide unit.
// Produces one result bit per RUN cycle, using shift-add for multiply and
// restoring division for divide. Every op takes a fixed 34 edges from the
// start edge to done.
// Ports:
//   clk, rst_n   rising-edge clock, async active-low reset
//   start        op request, sampled only while busy=0
//   funct3       0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   a, b         rs1 / rs2 operands
//   busy         op in flight (PREP/RUN/FIX)
//   done         one-cycle result-valid pulse
//   result       registered result, held until the next done
module rv32m_muldiv #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = 5;
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_FIX} state_t;

  state_t            state;
  state_t            next_state;
  logic              busy_d;
  logic              done_d;

  logic [2:0]        op;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              neg_q;
  logic              neg_r;
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;

  // Operand decode from the latched op
  logic              is_div;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;

  always_comb begin
    is_div = op[2];
    sa     = a_q[XLEN-1] & ((op == 3'd1) | (op == 3'd2) | (op == 3'd4) | (op == 3'd6));
    sb     = b_q[XLEN-1] & ((op == 3'd1) | (op == 3'd4) | (op == 3'd6));
    // Magnitudes viewed as unsigned, so |0x80000000| stays 0x80000000.
    abs_a  = sa ? XLEN'(-a_q) : a_q;
    abs_b  = sb ? XLEN'(-b_q) : b_q;
  end

  // One iteration step for each algorithm; acc holds {hi, lo}.
  // Multiply: hi = running partial product, lo = remaining multiplier bits.
  // Divide:   hi = partial remainder,      lo = dividend shifting into quotient.
  logic [XLEN:0]     mul_sum;
  logic [AW-1:0]     mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_fits;
  logic [XLEN-1:0]   div_rem;
  logic [AW-1:0]     div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[AW-1:XLEN]} + {1'b0, (acc[0] ? mag_a : XLEN'(0))};
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = {acc[AW-1:XLEN], acc[XLEN-1]};
    div_fits  = div_shift >= {1'b0, mag_b};
    div_rem   = div_fits ? XLEN'(div_shift - {1'b0, mag_b}) : div_shift[XLEN-1:0];
    div_next  = {div_rem, acc[XLEN-2:0], div_fits};
  end

  // Final sign fix and result select, with divide-by-zero forced here
  logic [AW-1:0]     prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod_fix = neg_q ? AW'(-acc) : acc;
    quo_fix  = neg_q ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
    rem_fix  = neg_r ? XLEN'(-acc[AW-1:XLEN]) : acc[AW-1:XLEN];
    case (op)
      3'd0:          fix_val = prod_fix[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:          fix_val = prod_fix[AW-1:XLEN];
      3'd4, 3'd5:    fix_val = (b_q == XLEN'(0)) ? {XLEN{1'b1}} : quo_fix;
      default:       fix_val = (b_q == XLEN'(0)) ? a_q : rem_fix;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state and registered-output decode
  always_comb begin
    next_state = state;
    done_d     = 1'b0;
    case (state)
      S_IDLE: if (start) next_state = S_PREP;
      S_PREP: next_state = S_RUN;
      S_RUN:  if (cnt == CW'(XLEN - 1)) next_state = S_FIX;
      S_FIX: begin
        next_state = S_IDLE;
        done_d     = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
    busy_d = (next_state != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op     <= 3'd0;
      a_q    <= '0;
      b_q    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        S_IDLE: begin
          if (start) begin
            op  <= funct3;
            a_q <= a;
            b_q <= b;
          end
        end
        S_PREP: begin
          mag_a <= abs_a;
          mag_b <= abs_b;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          cnt   <= '0;
          acc   <= is_div ? {XLEN'(0), abs_a} : {XLEN'(0), abs_b};
        end
        S_RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + CW'(1);
        end
        S_FIX: result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rv32m_muldiv.md
Name: rv32m_muldiv

Overview:
Iterative multi-cycle multiply/divide unit implementing the RV32M extension. It is the companion to the single-cycle integer ALU: it takes the same a/b operand buses and performs the multiply/divide ops the ALU does not cover. The core issues an op with a start pulse, stalls on busy, and captures result on done. One result bit per cycle via shift-add (multiply) or restoring division.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, and other values are illegal.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  op request; sampled only when busy=0
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  32  rs1 operand (multiplicand / dividend)
b  input  32  rs2 operand (multiplier / divisor)
busy  output  1  op in flight; core must stall
done  output  1  one-cycle pulse, result valid
result  output  32  registered result; held until the next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, all internal registers 0. Reset mid-operation aborts the op, and no done is produced.
- FSM states: IDLE, PREP, RUN, FIX.
- IDLE: if start=1, latch funct3, a and b, then go to PREP. The edge that samples start is edge 0.
- PREP (edge 1):
  - compute operand signs by op: MULH, DIV and REM take both signed; MULHSU takes a signed and b unsigned; the others are unsigned.
  - take absolute values.
  - record the result-negate flag.
  - clear the accumulator and counter.
  - go to RUN.
- RUN (edges 2..33): exactly 32 iterations with a 5-bit counter.
  - Multiply: 64-bit shift-add of |a| by |b|.
  - Divide: restoring division, producing 32 quotient bits and a 32-bit remainder.
  - After the iteration where the counter reaches 31, go to FIX.
- FIX (edge 34):
  - Conditionally two's-complement negate the result and select low/high/quotient/remainder.
  - Register result, set done=1 and go to IDLE.
- done is high for exactly one cycle, in the cycle after edge 34. It clears at the next edge.
- Latency is fixed at 34 edges for every op, including the special cases below; there is no early-out.
- busy=1 in PREP, RUN and FIX. busy=0 in IDLE, including the done cycle.
- start while busy=1 is ignored. It is neither queued nor does it disturb the op in flight.
- start in the done cycle is accepted, giving back-to-back ops with one idle-free turnaround.
- Changes on a, b or funct3 after edge 0 have no effect.
- Sign rules:
  - Product sign = sign(a) XOR sign(b) over the signed operands only.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Result select:
  - MUL: product[31:0]; the sign handling must not change the low word versus the unsigned result.
  - MULH, MULHSU, MULHU: product[63:32].
- Divide by zero (b=0):
  - DIV and DIVU: quotient = 0xFFFFFFFF.
  - REM and REMU: remainder = a.
  - These must fall out of, or be forced in, FIX with the same latency.
- Signed overflow (DIV or REM with a=0x80000000, b=0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- The absolute value of 0x80000000 is treated as unsigned 0x80000000, using a 33-bit or unsigned-view datapath so there is no overflow.

Test Plan:
- Reset held 3 cycles, then released: busy=0, done=0, result=0. Assert rst_n=0 at RUN cycle 10 of a MUL: no done pulse ever follows, and busy=0 immediately.
- MUL, a=7, b=0xFFFFFFFD: done exactly 34 cycles after the start edge, result=0xFFFFFFEB. MULH with 0x80000000 x 0x80000000: result=0x40000000. MULHU with 0xFFFFFFFF x 0xFFFFFFFF: result=0xFFFFFFFE. MULHSU with 0xFFFFFFFF x 0xFFFFFFFF: result=0xFFFFFFFF.
- DIV with a=0xFFFFFFF9 (-7), b=2: result=0xFFFFFFFD. REM with the same operands: result=0xFFFFFFFF. DIVU with 100 / 7: result=14. REMU with the same operands: result=2.
- Divide by zero with a=0x12345678, b=0:
  - DIV and DIVU give 0xFFFFFFFF.
  - REM and REMU give 0x12345678.
  - All four keep the 34-cycle latency.
- Overflow with a=0x80000000, b=0xFFFFFFFF: DIV gives 0x80000000 and REM gives 0.
- Handshake:
  - Pulse start again in RUN with different operands: it is ignored, and the first result is unchanged.
  - Assert start in the done cycle: the second op is accepted, and its done follows 34 cycles later.
  - result is held steady between the two done pulses.
